// File: rtl/peri_uart.sv
// peri_uart: memory-mapped UART with TX/RX FIFOs, programmable baud divider and RX-not-empty interrupt
module peri_uart #(
    parameter logic [19:0] BASE        = 20'h00010,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        peri_r,
    input  logic        peri_w,
    input  logic [27:0] peri_addr,
    input  logic [31:0] peri_wdata,
    output logic [31:0] peri_rdata,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          w_sel, w_wr_tx, w_rd_rx, w_rd_st, w_wr_div;
    logic [7:0]    w_off;
    logic [15:0]   w_div_q;
    logic [31:0]   w_rval;
    logic          w_unused;

    logic [15:0]   r_div;
    logic          r_ovr, r_ferr;
    logic [31:0]   r_rdata;

    logic [7:0]    r_txf [FIFO_DEPTH];
    logic [7:0]    r_rxf [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CW-1:0] r_tx_n, r_rx_n;
    logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

    state_t        r_tx_st, w_tx_nxt;
    logic          w_tx_load, w_tx_end;
    logic [15:0]   r_tx_div, r_tx_bc;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_sh;

    state_t        r_rx_st, w_rx_nxt;
    logic          r_rx_s1, r_rx_s2, w_rxs;
    logic          w_rx_load, w_rx_end, w_rx_mid, w_rx_stop;
    logic          r_rx_hold;
    logic [15:0]   r_rx_div, r_rx_bc;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;

    assign w_sel    = peri_addr[27:8] == BASE;
    assign w_off    = peri_addr[7:0];
    assign w_wr_tx  = peri_w && w_sel && w_off == 8'h00;
    assign w_rd_rx  = peri_r && w_sel && w_off == 8'h04;
    assign w_rd_st  = peri_r && w_sel && w_off == 8'h08;
    assign w_wr_div = peri_w && w_sel && w_off == 8'h0C;
    assign w_div_q  = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_unused = &{1'b0, peri_wdata[31:16]};

    assign w_tx_empty = r_tx_n == '0;
    assign w_tx_full  = r_tx_n == FULL;
    assign w_rx_empty = r_rx_n == '0;
    assign w_rx_full  = r_rx_n == FULL;
    assign w_tx_pop   = w_tx_load;
    assign w_tx_push  = w_wr_tx && (!w_tx_full || w_tx_pop);
    assign w_rx_pop   = w_rd_rx && !w_rx_empty;
    assign w_rx_push  = w_rx_stop && w_rxs && (!w_rx_full || w_rx_pop);

    assign w_rval = !w_sel           ? 32'd0 :
                    w_off == 8'h04   ? {24'd0, w_rx_empty ? 8'd0 : r_rxf[r_rx_rp]} :
                    w_off == 8'h08   ? {26'd0, r_ferr, r_ovr, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full} :
                    w_off == 8'h0C   ? {16'd0, r_div} : 32'd0;

    assign peri_rdata = r_rdata;
    assign irq        = !w_rx_empty;
    assign uart_tx    = (r_tx_st == START) ? 1'b0 : (r_tx_st == DATA) ? r_tx_sh[0] : 1'b1;

    // FIFO storage; contents need no reset because counts gate every read
    always_ff @(posedge clk) begin
        if (w_tx_push) r_txf[r_tx_wp] <= peri_wdata[7:0];
        if (w_rx_push) r_rxf[r_rx_wp] <= r_rx_sh;
    end

    // FIFO pointers and occupancy counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_tx_n  <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
            r_rx_n  <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            r_tx_n <= r_tx_n + CW'(w_tx_push) - CW'(w_tx_pop);
            r_rx_n <= r_rx_n + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    // Register file: divider, sticky error flags (new events beat the read-clear) and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= DEFAULT_DIV;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            if (w_wr_div) r_div <= peri_wdata[15:0];
            if (peri_r)   r_rdata <= w_rval;
            r_ovr  <= (w_rx_stop && w_rxs && w_rx_full && !w_rx_pop) || (r_ovr && !w_rd_st);
            r_ferr <= (w_rx_stop && !w_rxs) || (r_ferr && !w_rd_st);
        end
    end

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_st <= IDLE;
        else        r_tx_st <= w_tx_nxt;
    end

    assign w_tx_end = r_tx_bc == r_tx_div - 16'd1;

    // TX next state; the stop bit chains straight into the next start bit when data is waiting
    always_comb begin
        w_tx_nxt  = r_tx_st;
        w_tx_load = 1'b0;
        case (r_tx_st)
            IDLE:  if (!w_tx_empty) begin
                       w_tx_nxt  = START;
                       w_tx_load = 1'b1;
                   end
            START: if (w_tx_end) w_tx_nxt = DATA;
            DATA:  if (w_tx_end && r_tx_bit == 3'd7) w_tx_nxt = STOP;
            STOP:  if (w_tx_end) begin
                       w_tx_nxt  = w_tx_empty ? IDLE : START;
                       w_tx_load = !w_tx_empty;
                   end
            default: w_tx_nxt = IDLE;
        endcase
    end

    // TX datapath: frame divider latched at frame start, bit timer and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_div <= 16'd1;
            r_tx_bc  <= 16'd0;
            r_tx_bit <= 3'd0;
            r_tx_sh  <= 8'hFF;
        end else if (w_tx_load) begin
            r_tx_div <= w_div_q;
            r_tx_bc  <= 16'd0;
            r_tx_bit <= 3'd0;
            r_tx_sh  <= r_txf[r_tx_rp];
        end else if (r_tx_st != IDLE) begin
            r_tx_bc <= w_tx_end ? 16'd0 : r_tx_bc + 16'd1;
            if (w_tx_end && r_tx_st == DATA) begin
                r_tx_sh  <= r_tx_sh >> 1;
                r_tx_bit <= r_tx_bit + 3'd1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    assign w_rxs     = r_rx_s2;
    assign w_rx_end  = r_rx_bc == r_rx_div - 16'd1;
    assign w_rx_mid  = r_rx_bc == {1'b0, r_rx_div[15:1]};
    assign w_rx_stop = r_rx_st == STOP && !r_rx_hold && w_rx_end;

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_st <= IDLE;
        else        r_rx_st <= w_rx_nxt;
    end

    // RX next state; STOP lingers after its sample until the line is back high
    always_comb begin
        w_rx_nxt  = r_rx_st;
        w_rx_load = 1'b0;
        case (r_rx_st)
            IDLE:  if (!w_rxs) begin
                       w_rx_nxt  = START;
                       w_rx_load = 1'b1;
                   end
            START: if (w_rx_mid) w_rx_nxt = w_rxs ? IDLE : DATA;
            DATA:  if (w_rx_end && r_rx_bit == 3'd7) w_rx_nxt = STOP;
            STOP:  if (r_rx_hold && w_rxs) w_rx_nxt = IDLE;
            default: w_rx_nxt = IDLE;
        endcase
    end

    // RX datapath: half-bit alignment in START, then one sample per bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_div  <= 16'd1;
            r_rx_bc   <= 16'd0;
            r_rx_bit  <= 3'd0;
            r_rx_sh   <= 8'd0;
            r_rx_hold <= 1'b0;
        end else if (w_rx_load) begin
            r_rx_div  <= w_div_q;
            r_rx_bc   <= 16'd0;
            r_rx_bit  <= 3'd0;
            r_rx_hold <= 1'b0;
        end else if (r_rx_st == START) begin
            r_rx_bc <= w_rx_mid ? 16'd0 : r_rx_bc + 16'd1;
        end else if (r_rx_st == DATA) begin
            r_rx_bc <= w_rx_end ? 16'd0 : r_rx_bc + 16'd1;
            if (w_rx_end) begin
                r_rx_sh  <= {w_rxs, r_rx_sh[7:1]};
                r_rx_bit <= r_rx_bit + 3'd1;
            end
        end else if (r_rx_st == STOP && !r_rx_hold) begin
            r_rx_bc <= r_rx_bc + 16'd1;
            if (w_rx_end) r_rx_hold <= 1'b1;
        end
    end

endmodule

// File: tb/tb_peri_uart.sv
// tb_peri_uart: directed + randomized checks of peri_uart against a queue-based behavioural model
module tb_peri_uart;

    localparam logic [27:0] A = 28'h0001000;

    logic        clk = 1'b0, rst_n = 1'b0, peri_r = 1'b0, peri_w = 1'b0, uart_rx = 1'b1;
    logic [27:0] peri_addr = '0;
    logic [31:0] peri_wdata = '0;
    logic [31:0] peri_rdata;
    logic        uart_tx, irq;

    int          checks = 0, errors = 0;
    logic [7:0]  rxq[$];
    logic        m_ovr = 1'b0, m_ferr = 1'b0;
    logic [15:0] m_div = 16'd434;

    peri_uart dut (
        .clk(clk), .rst_n(rst_n), .peri_r(peri_r), .peri_w(peri_w),
        .peri_addr(peri_addr), .peri_wdata(peri_wdata), .peri_rdata(peri_rdata),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [27:0] a, input logic [31:0] d);
        peri_addr = a; peri_wdata = d; peri_w = 1'b1;
        @(negedge clk);
        peri_w = 1'b0;
    endtask

    task automatic rd(input logic [27:0] a, output logic [31:0] d);
        peri_addr = a; peri_r = 1'b1;
        @(negedge clk);
        peri_r = 1'b0;
        d = peri_rdata;
    endtask

    task automatic set_div(input logic [15:0] d);
        wr(A + 28'hC, {16'd0, d});
        m_div = d;
    endtask

    function automatic logic [31:0] m_status();
        return {26'd0, m_ferr, m_ovr, rxq.size() == 8, rxq.size() == 0, 1'b1, 1'b0};
    endfunction

    task automatic chk_status(input string tag);
        logic [31:0] d;
        rd(A + 28'h8, d);
        chk(tag, d, m_status());
        m_ovr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic chk_rx(input string tag);
        logic [31:0] d, e;
        e = (rxq.size() != 0) ? {24'd0, rxq.pop_front()} : 32'd0;
        rd(A + 28'h4, d);
        chk(tag, d, e);
    endtask

    task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
        for (int k = 0; k < 10; k++) begin
            uart_rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
            repeat (div) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (div + 4) @(negedge clk);
        if (!stop) m_ferr = 1'b1;
        else if (rxq.size() < 8) rxq.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic chk_tx(input string tag, input logic [31:0] bytes, input int n, input int div);
        int t, k, mism;
        logic [7:0] b;
        logic e;
        t = 0;
        while (uart_tx !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_start"}, {31'd0, uart_tx}, 32'd0);
        mism = 0;
        for (int i = 0; i < n * 10 * div; i++) begin
            if (i > 0) @(negedge clk);
            b = bytes[8 * (i / (10 * div)) +: 8];
            k = (i / div) % 10;
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            if (uart_tx !== e) mism++;
        end
        chk({tag, "_bits"}, mism, 32'd0);
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, uart_tx}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b0, b1;
        int          dv, t, mism;

        repeat (3) @(negedge clk);
        chk("rst_rdata", peri_rdata, 32'd0);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_status("rst_status");
        rd(A + 28'hC, d);
        chk("rst_div", d, 32'd434);

        set_div(16'd4);
        wr(A, 32'hA5);
        chk_tx("tx_a5", 32'hA5, 1, 4);
        chk_status("tx_done_status");

        for (int r = 0; r < 3; r++) begin
            dv = $urandom_range(1, 6);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            set_div(16'(dv));
            wr(A, {24'd0, b0});
            wr(A, {24'd0, b1});
            chk_tx("tx_b2b", {16'd0, b1, b0}, 2, dv);
        end

        set_div(16'd0);
        b0 = 8'($urandom);
        wr(A, {24'd0, b0});
        chk_tx("tx_div0", {24'd0, b0}, 1, 1);

        set_div(16'd8);
        chk("rx_irq_pre", {31'd0, irq}, 32'd0);
        send_rx(8'h3C, 8, 1'b1);
        chk("rx_irq_post", {31'd0, irq}, 32'd1);
        chk_rx("rx_3c");
        chk("rx_irq_clr", {31'd0, irq}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            dv = $urandom_range(4, 12);
            set_div(16'(dv));
            send_rx(8'($urandom), dv, $urandom_range(0, 3) != 0);
        end
        chk_status("rx_rand_status");
        while (rxq.size() != 0) chk_rx("rx_rand");
        chk_rx("rx_rand_empty");

        set_div(16'd8);
        for (int i = 1; i <= 9; i++) send_rx(8'(i), 8, 1'b1);
        chk("ovf_irq", {31'd0, irq}, 32'd1);
        chk_status("ovf_status");
        chk_status("ovf_status_clr");
        for (int i = 0; i < 8; i++) chk_rx("ovf_data");
        chk_status("ovf_status_end");

        send_rx(8'h55, 8, 1'b0);
        chk_status("ferr_status");
        chk("ferr_irq", {31'd0, irq}, 32'd0);
        chk_status("ferr_clr");

        chk_rx("empty_rd");
        send_rx(8'h96, 8, 1'b1);
        chk_rx("after_empty_rd");
        rd(A + 28'h10, d);
        chk("unmapped_rd", d, 32'd0);
        rd(28'h0002008, d);
        chk("unsel_rd", d, 32'd0);
        wr(28'h000200C, 32'h1234);
        rd(A + 28'hC, d);
        chk("unsel_wr", d, {16'd0, m_div});
        repeat (3) @(negedge clk);
        chk("rdata_hold", peri_rdata, {16'd0, m_div});
        wr(A + 28'h8, 32'hFF);
        wr(A + 28'h4, 32'hFF);
        chk_status("ro_wr");

        send_rx(8'h77, 8, 1'b1);
        set_div(16'd4);
        wr(A, 32'hA5);
        wr(A, 32'h3C);
        t = 0;
        while (uart_tx !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (17) @(negedge clk);
        chk("mid_bit3", {31'd0, uart_tx}, 32'd0);
        chk("mid_irq", {31'd0, irq}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_async_irq", {31'd0, irq}, 32'd0);
        chk("rst_async_rdata", peri_rdata, 32'd0);
        rxq.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_div = 16'd434;
        @(negedge clk);
        rst_n = 1'b1;
        mism = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) mism++;
        end
        chk("rst_no_resume", mism, 32'd0);
        chk_status("rst_mid_status");
        rd(A + 28'hC, d);
        chk("rst_mid_div", d, {16'd0, m_div});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
